// File: rtl/jerky_pattern_gen_pkg.sv
// ----------------------------------------------------------------------------
// jerky_pkg
//   Shared definitions for the one-hot pattern sequencer: the run-time mode
//   encoding and the period length of each mode.
// ----------------------------------------------------------------------------
package jerky_pkg;

    typedef enum logic [1:0] {
        MODE_JERKY  = 2'd0,
        MODE_WALK   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_JREV   = 2'd3
    } mode_e;

    // Number of steps in one period of the given mode for a WIDTH-bit word.
    function automatic int period(input mode_e mode, input int width);
        case (mode)
            MODE_WALK:   period = width;
            MODE_JERKY:  period = 2 * (width - 1);
            MODE_BOUNCE: period = 2 * (width - 1);
            MODE_JREV:   period = 2 * (width - 1);
            default:     period = 2 * (width - 1);
        endcase
    endfunction

endpackage

// File: rtl/jerky_pattern_gen_if.sv
// ----------------------------------------------------------------------------
// jerky_pattern_gen_if
//   Control/pattern bundle of the sequencer.
//     en      : advance one step on the clock edge
//     restart : jump to step 0 and load the requested mode
//     mode    : requested mode (see jerky_pkg::mode_e)
//     count   : one-hot pattern word (WIDTH bits)
//     last    : count shows the final step of the current period
//   master drives the controls, slave (the sequencer) drives the pattern.
// ----------------------------------------------------------------------------
interface jerky_pattern_gen_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             restart;
    logic [1:0]       mode;
    logic [WIDTH-1:0] count;
    logic             last;

    modport master (output en, output restart, output mode, input count, input last);
    modport slave  (input en, input restart, input mode, output count, output last);
endinterface

// File: rtl/jerky_pattern_gen_dec.sv
// ----------------------------------------------------------------------------
// jerky_pattern_dec
//   Combinational decoder from (mode, step index) to the one-hot pattern word.
//     mode_i   : pattern mode
//     idx_i    : step index within the period
//     onehot_o : WIDTH-bit one-hot word
//   Indices outside the period decode to the MSB, i.e. the reset pattern.
// ----------------------------------------------------------------------------
module jerky_pattern_dec
    import jerky_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IW    = $clog2(2 * WIDTH)
) (
    input  mode_e            mode_i,
    input  logic [IW-1:0]    idx_i,
    output logic [WIDTH-1:0] onehot_o
);

    int idx_s;
    int pos_s;

    // Select the lit bit position for this step, then expand to one-hot.
    always_comb begin
        idx_s    = int'(idx_i);
        pos_s    = WIDTH - 1;
        onehot_o = '0;
        if (idx_s < period(mode_i, WIDTH)) begin
            case (mode_i)
                // Even steps return home; odd steps walk away from it.
                MODE_JERKY:  pos_s = idx_i[0] ? (WIDTH - 2 - (idx_s - 1) / 2) : (WIDTH - 1);
                MODE_JREV:   pos_s = idx_i[0] ? (1 + (idx_s - 1) / 2) : 0;
                MODE_WALK:   pos_s = WIDTH - 1 - idx_s;
                MODE_BOUNCE: pos_s = (idx_s < WIDTH) ? (WIDTH - 1 - idx_s) : (idx_s - (WIDTH - 1));
                default:     pos_s = WIDTH - 1;
            endcase
        end else begin
            pos_s = WIDTH - 1;
        end
        for (int b = 0; b < WIDTH; b++) begin
            onehot_o[b] = (pos_s == b);
        end
    end

endmodule

// File: rtl/jerky_pattern_gen.sv
// ----------------------------------------------------------------------------
// jerky_pattern_gen
//   Parametrised one-hot pattern sequencer (JERKY, WALK, BOUNCE, JERKY_REV).
//     clk : clock, rising edge
//     rst : asynchronous reset, active-high
//     bus : slave side of jerky_pattern_gen_if (en, restart, mode in;
//           count, last out)
//   A requested mode change takes effect only at a period wrap or restart.
// ----------------------------------------------------------------------------
module jerky_pattern_gen
    import jerky_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    jerky_pattern_gen_if.slave  bus
);

    localparam int IW = $clog2(2 * WIDTH);
    localparam logic [WIDTH-1:0] RESET_PATTERN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [IW-1:0]    idx_q,   idx_d;
    mode_e            mode_q,  mode_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [IW-1:0]    last_idx_s;
    logic [WIDTH-1:0] dec_s;
    logic             load_s;

    assign last_idx_s = IW'(period(mode_q, WIDTH) - 1);

    // Pattern for the state being entered; feeds the count register.
    jerky_pattern_dec #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_dec (
        .mode_i   (mode_d),
        .idx_i    (idx_d),
        .onehot_o (dec_s)
    );

    // Next-state: restart beats en; wrap samples the requested mode.
    always_comb begin
        idx_d  = idx_q;
        mode_d = mode_q;
        load_s = 1'b0;
        if (bus.restart) begin
            idx_d  = '0;
            mode_d = mode_e'(bus.mode);
            load_s = 1'b1;
        end else if (bus.en) begin
            load_s = 1'b1;
            if (idx_q > last_idx_s) begin
                // Upset index: recover to the reset state.
                idx_d  = '0;
                mode_d = MODE_JERKY;
            end else if (idx_q == last_idx_s) begin
                idx_d  = '0;
                mode_d = mode_e'(bus.mode);
            end else begin
                idx_d  = idx_q + IW'(1);
            end
        end else begin
            load_s = 1'b0;
        end
        count_d = load_s ? dec_s : count_q;
    end

    // State registers with asynchronous reset to the MSB pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            mode_q  <= MODE_JERKY;
            count_q <= RESET_PATTERN;
        end else begin
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            count_q <= count_d;
        end
    end

    assign bus.count = count_q;
    assign bus.last  = (idx_q == last_idx_s);

endmodule

// File: tb/tb_jerky_pattern_gen.sv
// ----------------------------------------------------------------------------
// tb_jerky_pattern_gen
//   Directed bench for the one-hot sequencer at WIDTH 8, 4 and 2.
// ----------------------------------------------------------------------------
module tb_jerky_pattern_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jerky_pattern_gen_if #(.WIDTH(8)) if8 ();
    jerky_pattern_gen_if #(.WIDTH(4)) if4 ();
    jerky_pattern_gen_if #(.WIDTH(2)) if2 ();

    jerky_pattern_gen #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    jerky_pattern_gen #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    jerky_pattern_gen #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       en;
        logic       rs;
        logic [1:0] mode;
        logic [7:0] exp_c;
        logic       exp_l;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void add(input logic en, input logic rs, input logic [1:0] m,
                                input logic [7:0] c, input logic l);
        vec_t v;
        v.en = en; v.rs = rs; v.mode = m; v.exp_c = c; v.exp_l = l;
        tbl.push_back(v);
    endfunction

    task automatic step8(input logic en, input logic rs, input logic [1:0] m);
        if8.en = en; if8.restart = rs; if8.mode = m;
        @(posedge clk);
        #1;
    endtask

    task automatic step4(input logic en, input logic rs, input logic [1:0] m);
        if4.en = en; if4.restart = rs; if4.mode = m;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic en, input logic rs, input logic [1:0] m);
        if2.en = en; if2.restart = rs; if2.mode = m;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] t1 [14] = '{8'h40, 8'h80, 8'h20, 8'h80, 8'h10, 8'h80, 8'h08,
                            8'h80, 8'h04, 8'h80, 8'h02, 8'h80, 8'h01, 8'h80};
    logic [7:0] t2 [8]  = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    logic [7:0] t3 [14] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                            8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] t4a [5] = '{8'h40, 8'h80, 8'h20, 8'h80, 8'h10};
    logic [7:0] t4b [22] = '{8'h80, 8'h08, 8'h80, 8'h04, 8'h80, 8'h02, 8'h80, 8'h01,
                             8'h01, 8'h02, 8'h01, 8'h04, 8'h01, 8'h08, 8'h01, 8'h10,
                             8'h01, 8'h20, 8'h01, 8'h40, 8'h01, 8'h80};
    logic [3:0] t6a [6] = '{4'h4, 4'h8, 4'h2, 4'h8, 4'h1, 4'h8};

    initial begin
        rst = 1'b1;
        if8.en = 1'b0; if8.restart = 1'b0; if8.mode = 2'd0;
        if4.en = 1'b0; if4.restart = 1'b0; if4.mode = 2'd0;
        if2.en = 1'b0; if2.restart = 1'b0; if2.mode = 2'd0;

        // Table: JERKY run, WALK via restart, BOUNCE via wrap, holds, restart priority.
        for (int i = 0; i < 14; i++) begin
            add(1'b1, 1'b0, 2'd0, t1[i], i == 12);
            if (i == 12) add(1'b0, 1'b0, 2'd0, 8'h01, 1'b1);
        end
        add(1'b1, 1'b1, 2'd1, 8'h80, 1'b0);
        for (int i = 0; i < 8; i++) begin
            add(1'b1, 1'b0, (i == 7) ? 2'd2 : 2'd1, t2[i], i == 6);
        end
        for (int i = 0; i < 14; i++) begin
            add(1'b1, 1'b0, 2'd2, t3[i], i == 12);
            if (i == 6) begin
                add(1'b0, 1'b0, 2'd2, 8'h01, 1'b0);
                add(1'b0, 1'b0, 2'd0, 8'h01, 1'b0);
            end
        end
        add(1'b1, 1'b0, 2'd2, 8'h40, 1'b0);
        add(1'b0, 1'b1, 2'd0, 8'h80, 1'b0);
        add(1'b1, 1'b0, 2'd0, 8'h40, 1'b0);
        add(1'b1, 1'b0, 2'd0, 8'h80, 1'b0);

        #2;
        chk("rst_count8", 32'(if8.count), 32'h80);
        chk("rst_last8",  32'(if8.last),  32'h0);
        chk("rst_count4", 32'(if4.count), 32'h8);
        chk("rst_count2", 32'(if2.count), 32'h2);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            step8(tbl[i].en, tbl[i].rs, tbl[i].mode);
            chk($sformatf("tbl_count[%0d]", i), 32'(if8.count), 32'(tbl[i].exp_c));
            chk($sformatf("tbl_last[%0d]", i),  32'(if8.last),  32'(tbl[i].exp_l));
        end

        // Deferred switch to JERKY_REV with 3-cycle enable gaps.
        step8(1'b0, 1'b1, 2'd0);
        chk("t4_restart", 32'(if8.count), 32'h80);
        for (int i = 0; i < 5; i++) begin
            step8(1'b1, 1'b0, 2'd0);
            chk("t4_pre", 32'(if8.count), 32'(t4a[i]));
        end
        for (int i = 0; i < 22; i++) begin
            step8(1'b1, 1'b0, 2'd3);
            chk($sformatf("t4_count[%0d]", i), 32'(if8.count), 32'(t4b[i]));
            chk($sformatf("t4_last[%0d]", i),  32'(if8.last),  32'(i == 7 || i == 21));
            for (int g = 0; g < 3; g++) begin
                step8(1'b0, 1'b0, 2'd3);
                chk("t4_gap", 32'(if8.count), 32'(t4b[i]));
            end
        end

        // Asynchronous reset mid-period at idx 7.
        step8(1'b0, 1'b1, 2'd0);
        for (int i = 0; i < 7; i++) step8(1'b1, 1'b0, 2'd0);
        chk("t5_pre", 32'(if8.count), 32'h08);
        if8.en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_async_count", 32'(if8.count), 32'h80);
        chk("t5_async_last",  32'(if8.last),  32'h0);
        #1;
        rst = 1'b0;

        // WIDTH=4 JERKY.
        for (int i = 0; i < 6; i++) begin
            step4(1'b1, 1'b0, 2'd0);
            chk($sformatf("w4_count[%0d]", i), 32'(if4.count), 32'(t6a[i]));
            chk($sformatf("w4_last[%0d]", i),  32'(if4.last),  32'(i == 4));
        end
        if4.en = 1'b0;

        // WIDTH=2 BOUNCE.
        step2(1'b1, 1'b1, 2'd2);
        chk("w2_count0", 32'(if2.count), 32'h2);
        chk("w2_last0",  32'(if2.last),  32'h0);
        step2(1'b1, 1'b0, 2'd2);
        chk("w2_count1", 32'(if2.count), 32'h1);
        chk("w2_last1",  32'(if2.last),  32'h1);
        step2(1'b1, 1'b0, 2'd2);
        chk("w2_count2", 32'(if2.count), 32'h2);
        chk("w2_last2",  32'(if2.last),  32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
